// File: rtl/arb_4_rr_hold.sv
// arb_4_rr_hold: N-way round-robin arbiter with registered, held grants.
// A lowest-index-first search runs over the request vector rotated by a
// registered pointer. The owner keeps the grant until it drops its request.
// Optional macro ARB_HOLD_LIMIT_EN: forces a handover once an owner has held
// the grant for MAX_HOLD cycles while another requester is waiting.
module arb_4_rr_hold #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic [IDW-1:0]  gnt_id_q, gnt_id_d;
    logic [IDW-1:0]  ptr_q, ptr_d;

    logic [N-1:0]    search_req_s;
    logic            found_s;
    logic [IDW-1:0]  win_s;
    logic            owner_req_s;
    logic            others_req_s;
    logic            force_s;

    // Lowest-index-first search on req rotated right by p. Returns
    // {found, winner}, where winner is already mapped back to an absolute
    // index. The index is wrapped by subtraction, so it never reaches N.
    function automatic logic [IDW:0] rr_search(input logic [N-1:0]   r,
                                               input logic [IDW-1:0] p);
        logic [IDW:0]   res;
        logic [IDW-1:0] pos;
        int             idx;
        res = {(IDW+1){1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            idx = ((i + int'(p)) >= N) ? (i + int'(p) - N) : (i + int'(p));
            pos = idx[IDW-1:0];
            if (r[pos]) begin
                res = {1'b1, pos};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Pointer value that makes the requester after w the highest priority.
    function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] w);
        int nxt;
        nxt = int'(w) + 1;
        if (nxt >= N) begin
            nxt = 0;
        end else begin
            nxt = nxt;
        end
        return nxt[IDW-1:0];
    endfunction

    // One-hot encoding of an index.
    function automatic logic [N-1:0] onehot(input logic [IDW-1:0] w);
        logic [N-1:0] res;
        res    = {N{1'b0}};
        res[w] = 1'b1;
        return res;
    endfunction

    // Owner still wants the resource / somebody else is waiting.
    always_comb begin
        owner_req_s  = req[gnt_id_q];
        others_req_s = |(req & ~gnt_q);
    end

`ifdef ARB_HOLD_LIMIT_EN
    localparam int            HW        = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    // Hold limit reached with a waiter present: take the grant away.
    always_comb begin
        force_s = (state_q == BUSY) && owner_req_s && others_req_s &&
                  (hold_cnt_q == HOLD_LAST);
    end
`else
    logic unused_hold_cfg_s;
    assign unused_hold_cfg_s = (MAX_HOLD >= 2);
    assign force_s = 1'b0;
`endif

    // Search input: on a forced handover, the current owner is masked out.
    always_comb begin
        if (force_s) begin
            search_req_s = req & ~gnt_q;
        end else begin
            search_req_s = req;
        end
    end

    // Rotated fixed-priority search.
    always_comb begin
        {found_s, win_s} = rr_search(search_req_s, ptr_q);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        ptr_d       = ptr_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    state_d     = BUSY;
                    gnt_d       = onehot(win_s);
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = win_s;
                    ptr_d       = ptr_after(win_s);
                end else begin
                    state_d     = IDLE;
                    gnt_d       = {N{1'b0}};
                    gnt_valid_d = 1'b0;
                    gnt_id_d    = {IDW{1'b0}};
                end
            end
            BUSY: begin
                if (owner_req_s && !force_s) begin
                    state_d = BUSY;
                end else if (found_s) begin
                    // Direct handover, no idle cycle in between.
                    state_d     = BUSY;
                    gnt_d       = onehot(win_s);
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = win_s;
                    ptr_d       = ptr_after(win_s);
                end else begin
                    state_d     = IDLE;
                    gnt_d       = {N{1'b0}};
                    gnt_valid_d = 1'b0;
                    gnt_id_d    = {IDW{1'b0}};
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = {N{1'b0}};
                gnt_valid_d = 1'b0;
                gnt_id_d    = {IDW{1'b0}};
                ptr_d       = {IDW{1'b0}};
            end
        endcase
    end

`ifdef ARB_HOLD_LIMIT_EN
    // Consecutive cycles with an unchanged owner; saturates at the limit.
    always_comb begin
        if ((state_q == BUSY) && (state_d == BUSY) && (gnt_d == gnt_q)) begin
            if (hold_cnt_q == HOLD_LAST) begin
                hold_cnt_d = hold_cnt_q;
            end else begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end else begin
            hold_cnt_d = {HW{1'b0}};
        end
    end
`endif

    // State, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= {N{1'b0}};
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= {IDW{1'b0}};
            ptr_q       <= {IDW{1'b0}};
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_q  <= {HW{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            ptr_q       <= ptr_d;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_q  <= hold_cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_arb_4_rr_hold.sv
// Testbench for arb_4_rr_hold: directed vector table, reset/hold sequences,
// and a random run checked against rule-based expectations.
module tb_arb_4_rr_hold;

    localparam int N        = 4;
    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;

    int n_pass  = 0;
    int n_total = 0;

    arb_4_rr_hold #(.N(N), .IDW(2), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       vld;
    } vec_t;

    vec_t tbl [28];

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] g,
                                input logic [1:0] i, input logic v);
        vec_t x;
        x.req = r; x.gnt = g; x.id = i; x.vld = v;
        return x;
    endfunction

    function automatic logic [31:0] outs();
        return {25'd0, gnt, gnt_id, gnt_valid};
    endfunction

    function automatic logic [31:0] pack(input logic [3:0] g, input logic [1:0] i,
                                         input logic v);
        return {25'd0, g, i, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] r, pg;
    logic [1:0] pid;
    logic       pv;
    logic       ok;
    int         run;
    int         wcnt [4];
    int         worst;

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;

        for (int i = 0; i < 5; i++) tbl[i] = mk(4'b0000, 4'b0000, 2'd0, 1'b0);
        tbl[5]  = mk(4'b1111, 4'b0001, 2'd0, 1'b1);
        tbl[6]  = mk(4'b1111, 4'b0001, 2'd0, 1'b1);
        tbl[7]  = mk(4'b1111, 4'b0001, 2'd0, 1'b1);
        tbl[8]  = mk(4'b1110, 4'b0010, 2'd1, 1'b1);
        tbl[9]  = mk(4'b1111, 4'b0010, 2'd1, 1'b1);
        tbl[10] = mk(4'b1111, 4'b0010, 2'd1, 1'b1);
        tbl[11] = mk(4'b1101, 4'b0100, 2'd2, 1'b1);
        tbl[12] = mk(4'b1111, 4'b0100, 2'd2, 1'b1);
        tbl[13] = mk(4'b1111, 4'b0100, 2'd2, 1'b1);
        tbl[14] = mk(4'b1011, 4'b1000, 2'd3, 1'b1);
        tbl[15] = mk(4'b1111, 4'b1000, 2'd3, 1'b1);
        tbl[16] = mk(4'b1111, 4'b1000, 2'd3, 1'b1);
        tbl[17] = mk(4'b0111, 4'b0001, 2'd0, 1'b1);
        tbl[18] = mk(4'b0000, 4'b0000, 2'd0, 1'b0);
        tbl[19] = mk(4'b0100, 4'b0100, 2'd2, 1'b1);
        tbl[20] = mk(4'b0000, 4'b0000, 2'd0, 1'b0);
        tbl[21] = mk(4'b0101, 4'b0001, 2'd0, 1'b1);
        tbl[22] = mk(4'b0000, 4'b0000, 2'd0, 1'b0);
        tbl[23] = mk(4'b1010, 4'b0010, 2'd1, 1'b1);
        tbl[24] = mk(4'b1000, 4'b1000, 2'd3, 1'b1);
        tbl[25] = mk(4'b1001, 4'b1000, 2'd3, 1'b1);
        tbl[26] = mk(4'b0001, 4'b0001, 2'd0, 1'b1);
        tbl[27] = mk(4'b0000, 4'b0000, 2'd0, 1'b0);

        apply_reset();
        #1;
        check("reset_state", outs(), pack(4'b0000, 2'd0, 1'b0));

        // Directed vectors: drive on negedge, sample 1 time unit after posedge.
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            req = tbl[i].req;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), outs(), pack(tbl[i].gnt, tbl[i].id, tbl[i].vld));
        end

        // Asynchronous reset in the middle of a grant (pointer is at 1 here).
        @(negedge clk);
        req = 4'b0010;
        @(posedge clk);
        #1;
        check("pre_async_rst", outs(), pack(4'b0010, 2'd1, 1'b1));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_clear", outs(), pack(4'b0000, 2'd0, 1'b0));
        @(negedge clk);
        req = 4'b0001;
        @(posedge clk);
        #1;
        check("held_in_rst", outs(), pack(4'b0000, 2'd0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_edge", outs(), pack(4'b0000, 2'd0, 1'b0));
        @(posedge clk);
        #1;
        check("first_after_rst", outs(), pack(4'b0001, 2'd0, 1'b1));

        // Owner 1 keeps requesting for 20 cycles while requester 3 waits.
        apply_reset();
        @(negedge clk);
        req = 4'b1010;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
`ifdef ARB_HOLD_LIMIT_EN
            if (c > MAX_HOLD) begin
                check($sformatf("hold_c%0d", c), outs(), pack(4'b1000, 2'd3, 1'b1));
            end else begin
                check($sformatf("hold_c%0d", c), outs(), pack(4'b0010, 2'd1, 1'b1));
            end
`else
            check($sformatf("hold_c%0d", c), outs(), pack(4'b0010, 2'd1, 1'b1));
`endif
        end

        // Random run with rule-based checks.
        apply_reset();
        pg = 4'b0000; pid = 2'd0; pv = 1'b0; run = 0; worst = 0;
        for (int i = 0; i < 4; i++) wcnt[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            end
            r = req;
            @(posedge clk);
            #1;

            // Encoding consistency.
            ok = ((gnt & (gnt - 4'd1)) == 4'd0) && (gnt_valid == (|gnt)) &&
                 (gnt_valid ? (gnt == (4'd1 << gnt_id)) : (gnt_id == 2'd0));
            check($sformatf("rand_enc_c%0d", cyc), {31'd0, ok}, 32'd1);

            // Expected grant behaviour given previous owner and sampled req.
            if (pv && r[pid]
`ifdef ARB_HOLD_LIMIT_EN
                && !((run >= MAX_HOLD) && ((r & ~pg) != 4'd0))
`endif
               ) begin
                ok = (gnt == pg) && gnt_valid;
            end else if (r != 4'd0) begin
                ok = gnt_valid && ((gnt & r) != 4'd0) && (gnt != pg);
            end else begin
                ok = (gnt == 4'd0) && !gnt_valid;
            end
            check($sformatf("rand_rule_c%0d", cyc), {31'd0, ok}, 32'd1);

            // Fairness: count new grants given to others while i waits.
            for (int i = 0; i < 4; i++) begin
                if (r[i] && !gnt[i]) begin
                    if (gnt_valid && (gnt != pg)) wcnt[i]++;
                end else begin
                    wcnt[i] = 0;
                end
                if (wcnt[i] > worst) worst = wcnt[i];
            end

            if (gnt_valid && pv && (gnt == pg)) run++;
            else run = gnt_valid ? 1 : 0;
            pg = gnt; pid = gnt_id; pv = gnt_valid;
        end
        check("rand_wait_bound", {31'd0, (worst <= N - 1)}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/arb_4_rr_hold.md
Name: arb_4_rr_hold

Overview:
- Sequential round-robin arbiter sharing one resource between N requesters (default 4).
- Built on the same fixed-priority "lowest index wins" search as the combinational 4-bit LSB arbiter. The search is applied to a request vector rotated by a registered round-robin pointer.
- Grants are registered and held for the whole transaction, i.e. until the owner drops its request.
- Sits in front of any shared datapath port (bus, memory bank, ALU) that needs multi-cycle ownership.

Parameters:
- N, 4: number of requesters; must be 2..16.
- IDW, 2: width of gnt_id; must equal ceil(log2(N)).
- MAX_HOLD, 16: maximum consecutive grant cycles while others wait. Used only with ARB_HOLD_LIMIT_EN; must be ≥ 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  request vector; req[i] high means requester i wants or keeps the resource
- gnt  output  N  registered one-hot grant, or all zero
- gnt_valid  output  1  registered; equals |gnt
- gnt_id  output  IDW  registered binary index of the owner; 0 when gnt_valid=0

Behaviour:
- Reset (rst_n low, asynchronous):
  - gnt=0, gnt_valid=0, gnt_id=0.
  - state=IDLE, ptr=0 (index 0 highest priority).
  - Hold counter=0.
- Reset may assert mid-grant. Outputs clear immediately, without waiting for a clock edge. First grant after release needs a clk edge with req≠0.
- States:
  - IDLE: no owner.
  - BUSY: owner = gnt_id.
- Arbitration search:
  - Rotate req right by ptr.
  - Apply lowest-index-first priority.
  - Winner w = (found index + ptr) mod N.
  - Search is purely combinational; all outputs change only on clk.
- Each rising edge:
  - IDLE, req==0: stay IDLE; outputs 0.
  - IDLE, req≠0: go BUSY; gnt=1<<w, gnt_id=w, gnt_valid=1; ptr=(w+1) mod N.
  - BUSY, req[owner]==1: hold. Outputs and ptr unchanged.
  - BUSY, req[owner]==0, other req≠0: hand over directly to the new winner w, with no idle bubble. ptr=(w+1) mod N.
  - BUSY, req==0: go IDLE; outputs 0; ptr unchanged.
- Latency: a request sampled at edge k (resource free) is granted in the cycle following edge k (registered, 1 cycle).
- Release: the owner drops req in cycle t, and gnt moves or clears at the next edge.
- Boundary conditions:
  - Owner re-raising req in the same cycle it drops is impossible: req is sampled once per edge.
  - If the owner's req falls and others request, the former owner has lowest priority (ptr already past it).
  - Simultaneous requests from all N from reset: grant order is 0,1,2,3,0…, each held as long as its req stays high.
  - ptr wraps from N-1 to 0 via mod N. Non-power-of-two N must never yield an index ≥ N.
- Invariant: gnt is always zero or one-hot, and gnt_id matches gnt.

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN.
- Defined:
  - A hold counter (width ceil(log2(MAX_HOLD))+1) counts consecutive BUSY cycles with the same owner.
  - The counter clears on every grant change and in IDLE.
  - If the counter reaches MAX_HOLD-1 while req[owner]==1 and any other req bit is high, the next edge forces re-arbitration with the owner masked out. Ownership passes to the winner, ptr=(w+1) mod N, and the counter clears.
  - If no other requester is waiting, the owner keeps the grant and the counter saturates.
- Undefined: no counter logic; the owner holds indefinitely; MAX_HOLD is ignored.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> gnt=0, gnt_valid=0, gnt_id=0 every cycle. Assert rst_n low mid-grant -> gnt=0 without a clk edge.
- req=4'b1111 held, each owner drops its own req for 1 cycle after 3 cycles of grant, then re-raises it -> grant sequence 0001,0010,0100,1000,0001. Each grant lasts 3 cycles, handovers have no bubble, gnt_id=0,1,2,3,0.
- Idle arbiter, req=4'b0100 at edge k -> gnt=0100, gnt_id=2 after edge k. Drop req -> gnt=0 the next edge. Then req=4'b0101 -> gnt=1000 never; gnt=0001 (ptr=3 wraps, 0 wins before 2).
- Owner 1 holds 20 cycles while req[3] is high -> without the macro gnt stays 0010 for all 20 cycles. With ARB_HOLD_LIMIT_EN and MAX_HOLD=16 -> gnt switches to 1000 after exactly 16 cycles of 0010.
- Random req (10k cycles) with scoreboard -> gnt always zero or one-hot; gnt_id consistent; no requester waits more than N-1 grants. With the macro, no grant lasts more than MAX_HOLD cycles when others request.
